// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
// Bundles the controller-side signals of the multiply/divide unit.
//   master : controller / register-file side (drives start, op, operands, MTHI/MTLO)
//   slave  : mult_div_unit itself (drives busy, done, divByZero, hi, lo)
// Ports carried:
//   start, op[1:0], opA, opB     - operation launch and operands
//   writeHi, writeLo, writeData  - MTHI / MTLO path
//   busy, done, divByZero        - status handshake
//   hi, lo                       - HI/LO readout for MFHI/MFLO
//   abort                        - only present when MDU_ABORT_EN is defined
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             writeHi;
  logic             writeLo;
  logic [WIDTH-1:0] writeData;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_ABORT_EN
  logic             abort;
`endif

  modport master (
`ifdef MDU_ABORT_EN
    output abort,
`endif
    output start, op, opA, opB, writeHi, writeLo, writeData,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
`ifdef MDU_ABORT_EN
    input  abort,
`endif
    input  start, op, opA, opB, writeHi, writeLo, writeData,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative WIDTH-bit multiply/divide unit for the MIPS datapath. Runs
// MULTU/MULT/DIVU/DIV in WIDTH iteration cycles plus one sign-fixup cycle,
// holding the result in HI/LO. MTHI/MTLO writes are accepted only when idle.
// Ports:
//   clk    - clock, all state updates on posedge
//   reset  - asynchronous, active-high; clears all state
//   bus    - mult_div_unit_if.slave (start/op/opA/opB, writeHi/writeLo/writeData,
//            busy/done/divByZero/hi/lo)
// Optional feature: define MDU_ABORT_EN to add bus.abort, which cancels a
// running operation without touching HI/LO/divByZero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  mult_div_unit_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  // acc_hi/acc_lo hold the running product (hi:lo) for multiply, or the
  // partial remainder (hi) and dividend-shifting-into-quotient (lo) for divide.
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   operand_b_q, operand_b_d;
  logic               is_div_q, is_div_d;
  logic               neg_result_q, neg_result_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_by_zero_q, div_by_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes and sign bits for signed ops, computed from the live buses
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // Iteration datapath
  logic [WIDTH-1:0]   mult_addend;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;

  // Fixup datapath
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  always_comb begin
    signed_op = bus.op[0];
    a_neg     = signed_op & bus.opA[WIDTH-1];
    b_neg     = signed_op & bus.opB[WIDTH-1];
    mag_a     = a_neg ? -bus.opA : bus.opA;
    mag_b     = b_neg ? -bus.opB : bus.opB;

    mult_addend = acc_lo_q[0] ? operand_b_q : '0;
    mult_sum    = {1'b0, acc_hi_q} + {1'b0, mult_addend};

    // Restoring division: the remainder never exceeds the divisor, so the
    // shifted value fits WIDTH+1 bits and the trial sign bit decides restore.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand_b_q};

    product       = {acc_hi_q, acc_lo_q};
    product_fixed = neg_result_q ? -product : product;
    quo_fixed     = neg_result_q ? -acc_lo_q : acc_lo_q;
    rem_fixed     = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  // Next-state logic. For a zero divisor the restoring loop naturally leaves
  // the dividend magnitude in the remainder, so re-applying the dividend sign
  // recovers opA exactly; only the quotient needs forcing to all ones.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    acc_hi_d      = acc_hi_q;
    acc_lo_d      = acc_lo_q;
    operand_b_d   = operand_b_q;
    is_div_d      = is_div_q;
    neg_result_d  = neg_result_q;
    neg_rem_d     = neg_rem_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;
    hi_d          = hi_q;
    lo_d          = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.writeHi) hi_d = bus.writeData;
        if (bus.writeLo) lo_d = bus.writeData;
        if (bus.start) begin
          state_d       = RUN;
          count_d       = '0;
          acc_hi_d      = '0;
          acc_lo_d      = mag_a;
          operand_b_d   = mag_b;
          is_div_d      = bus.op[1];
          neg_result_d  = a_neg ^ b_neg;
          neg_rem_d     = a_neg;
          busy_d        = 1'b1;
          div_by_zero_d = 1'b0;
        end
      end

      RUN: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH]) begin
            acc_hi_d = div_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mult_sum[WIDTH:1];
          acc_lo_d = {mult_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIXUP;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      FIXUP: begin
        if (is_div_q) begin
          hi_d          = rem_fixed;
          lo_d          = (operand_b_q == '0) ? '1 : quo_fixed;
          div_by_zero_d = (operand_b_q == '0);
        end else begin
          hi_d = product_fixed[2*WIDTH-1:WIDTH];
          lo_d = product_fixed[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef MDU_ABORT_EN
    // Abort wins over everything a running operation would do this edge,
    // including the FIXUP write-back.
    if (bus.abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      hi_d          = hi_q;
      lo_d          = lo_q;
      div_by_zero_d = div_by_zero_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      acc_hi_q      <= '0;
      acc_lo_q      <= '0;
      operand_b_q   <= '0;
      is_div_q      <= 1'b0;
      neg_result_q  <= 1'b0;
      neg_rem_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      acc_hi_q      <= acc_hi_d;
      acc_lo_q      <= acc_lo_d;
      operand_b_q   <= operand_b_d;
      is_div_q      <= is_div_d;
      neg_result_q  <= neg_result_d;
      neg_rem_q     <= neg_rem_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.divByZero = div_by_zero_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
